// File: rtl/collision_counter_pkg.sv
// Shared definitions for the collision score path: default sizing that the
// score display also relies on, FSM state encoding, and the cooldown timer
// width helper.
package collision_counter_pkg;

    // Score width shared with the two-digit score display.
    localparam int unsigned CC_COUNT_W         = 6;
    localparam int unsigned CC_MAX_COUNT       = 63;
    localparam int unsigned CC_GAME_OVER_COUNT = 10;
    localparam int unsigned CC_COOLDOWN_FRAMES = 30;

    // Game flow states, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_COOLDOWN  = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // Bits needed to hold 0..frames; a zero-length cooldown still gets one bit.
    function automatic int unsigned timer_width(input int unsigned frames);
        return (frames == 0) ? 1 : $clog2(frames + 1);
    endfunction

endpackage

// File: rtl/collision_counter_frame_cooldown_timer.sv
// Invulnerability cooldown timer, counted in video frames. Loaded with the full
// cooldown length on a counted hit, decremented by each FrameTick while the
// game is cooling down, and reports the tick that ends the cooldown.
module collision_counter_frame_cooldown_timer
    import collision_counter_pkg::*;
#(
    parameter int unsigned FRAMES = CC_COOLDOWN_FRAMES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic load,
    input  logic run,
    input  logic tick,
    output logic done
);

    localparam int unsigned   TW       = timer_width(FRAMES);
    localparam logic [TW-1:0] LOAD_VAL = TW'(FRAMES);

    logic [TW-1:0] remaining;

    // Frames left in the current cooldown; never decrements below zero.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= LOAD_VAL;
        end else if (run && tick && (remaining != '0)) begin
            remaining <= remaining - TW'(1);
        end
    end

    // The FrameTick that consumes the last remaining frame ends the cooldown.
    assign done = run && tick && (remaining == TW'(1));

endmodule

// File: rtl/collision_counter.sv
// Collision scoring: turns the raw car/obstacle overlap level into counted hits
// with rising-edge detection, a per-hit cooldown measured in frames, a
// saturating score and a game-over flag. Feeds the two-digit score display.
module collision_counter
    import collision_counter_pkg::*;
#(
    parameter int unsigned COUNT_W         = CC_COUNT_W,
    parameter int unsigned MAX_COUNT       = CC_MAX_COUNT,
    parameter int unsigned GAME_OVER_COUNT = CC_GAME_OVER_COUNT,
    parameter int unsigned COOLDOWN_FRAMES = CC_COOLDOWN_FRAMES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               StartGame,
    input  logic               FrameTick,
    input  logic               CollisionIn,
    output logic [COUNT_W-1:0] Collision,
    output logic               DisplayEnable,
    output logic               HitPulse,
    output logic               GameOver
);

    localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

    state_t             state;
    state_t             state_nxt;
    logic               collision_prev;
    logic               hit;
    logic [COUNT_W-1:0] count_inc;
    logic [COUNT_W-1:0] count_nxt;
    logic               hit_pulse_nxt;
    logic               timer_load;
    logic               timer_done;
    logic               in_cooldown;

    // Only a fresh overlap counts; a held level never produces a second hit.
    assign hit         = CollisionIn & ~collision_prev;
    assign in_cooldown = (state == ST_COOLDOWN);

    // Saturating increment: at the ceiling the score simply holds.
    assign count_inc = (Collision >= MAX_VAL) ? MAX_VAL : Collision + COUNT_W'(1);

    collision_counter_frame_cooldown_timer #(
        .FRAMES (COOLDOWN_FRAMES)
    ) u_cooldown (
        .Clock (Clock),
        .Reset (Reset),
        .clear (StartGame),
        .load  (timer_load),
        .run   (in_cooldown),
        .tick  (FrameTick),
        .done  (timer_done)
    );

    // Next state, next score and hit pulse; StartGame overrides everything.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        count_nxt     = Collision;
        hit_pulse_nxt = 1'b0;
        timer_load    = 1'b0;

        if (StartGame) begin
            state_nxt = ST_ARMED;
            count_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Waiting for the first game; overlaps are ignored.
                end
                ST_ARMED: begin
                    if (hit) begin
                        count_nxt     = count_inc;
                        hit_pulse_nxt = 1'b1;
                        // Zero-extended compare so an unreachable game-over
                        // count (above the ceiling) never matches.
                        if (32'(count_inc) == GAME_OVER_COUNT) begin
                            state_nxt = ST_GAME_OVER;
                        end else if (COOLDOWN_FRAMES != 0) begin
                            state_nxt  = ST_COOLDOWN;
                            timer_load = 1'b1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (timer_done) begin
                        state_nxt = ST_ARMED;
                    end
                end
                ST_GAME_OVER: begin
                    // Score frozen until the next StartGame.
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, score and all outputs registered; Reset wins over every input.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= ST_IDLE;
            collision_prev <= 1'b0;
            Collision      <= '0;
            DisplayEnable  <= 1'b0;
            HitPulse       <= 1'b0;
            GameOver       <= 1'b0;
        end else begin
            state          <= state_nxt;
            collision_prev <= CollisionIn;
            Collision      <= count_nxt;
            DisplayEnable  <= (state_nxt != ST_IDLE);
            HitPulse       <= hit_pulse_nxt;
            GameOver       <= (state_nxt == ST_GAME_OVER);
        end
    end

endmodule

// File: tb/tb_collision_counter.sv
// Bench for collision_counter: two instances (default build, and a build with
// no cooldown and an unreachable game-over count) share one stimulus stream.
// A frame-level game model predicts every output each cycle; directed
// scenarios add explicit expected constants.
module tb_collision_counter;

    logic       Clock = 1'b0;
    logic       Reset, StartGame, FrameTick, CollisionIn;
    logic [5:0] coll_a, coll_b;
    logic       de_a, de_b, hp_a, hp_b, go_a, go_b;

    always #5 Clock = ~Clock;

    collision_counter dut_a (
        .Clock         (Clock),
        .Reset         (Reset),
        .StartGame     (StartGame),
        .FrameTick     (FrameTick),
        .CollisionIn   (CollisionIn),
        .Collision     (coll_a),
        .DisplayEnable (de_a),
        .HitPulse      (hp_a),
        .GameOver      (go_a)
    );

    collision_counter #(
        .COUNT_W         (6),
        .MAX_COUNT       (63),
        .GAME_OVER_COUNT (100),
        .COOLDOWN_FRAMES (0)
    ) dut_b (
        .Clock         (Clock),
        .Reset         (Reset),
        .StartGame     (StartGame),
        .FrameTick     (FrameTick),
        .CollisionIn   (CollisionIn),
        .Collision     (coll_b),
        .DisplayEnable (de_b),
        .HitPulse      (hp_b),
        .GameOver      (go_b)
    );

    // Game model: score, frames of invulnerability left, and game flags.
    typedef struct packed {
        int count;
        int cool;
        bit started;
        bit over;
        bit prev;
        bit pulse;
    } mdl_t;

    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses_b = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic mdl_t step(input mdl_t m, input int cf, input int go, input int maxc,
                                  input bit rst, input bit sg, input bit ft, input bit ci);
        mdl_t n = m;
        bit   h = ci && !m.prev;
        if (rst) begin
            n = '0;
            return n;
        end
        n.pulse = 1'b0;
        if (sg) begin
            n.started = 1'b1;
            n.over    = 1'b0;
            n.count   = 0;
            n.cool    = 0;
        end else if (m.started && !m.over) begin
            if (m.cool > 0) begin
                if (ft) n.cool = m.cool - 1;
            end else if (h) begin
                n.pulse = 1'b1;
                if (m.count < maxc) n.count = m.count + 1;
                if (n.count == go) n.over = 1'b1;
                else n.cool = cf;
            end
        end
        n.prev = ci;
        return n;
    endfunction

    // One clock: drive inputs, advance both models, compare all outputs.
    task automatic cyc(input bit rst, input bit sg, input bit ft, input bit ci);
        Reset       = rst;
        StartGame   = sg;
        FrameTick   = ft;
        CollisionIn = ci;
        @(posedge Clock);
        ma = step(ma, 30, 10, 63, rst, sg, ft, ci);
        mb = step(mb, 0, 100, 63, rst, sg, ft, ci);
        #1;
        if (hp_b) pulses_b++;
        check("a.coll", int'(coll_a), ma.count);
        check("a.pulse", int'(hp_a), int'(ma.pulse));
        check("a.over", int'(go_a), int'(ma.over));
        check("a.disp", int'(de_a), int'(ma.started));
        check("b.coll", int'(coll_b), mb.count);
        check("b.pulse", int'(hp_b), int'(mb.pulse));
        check("b.over", int'(go_b), int'(mb.over));
        check("b.disp", int'(de_b), int'(mb.started));
    endtask

    // n video frames, each three clocks long, with CollisionIn held at ci.
    task automatic frames(input int n, input bit ci);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1, ci);
            cyc(1'b0, 1'b0, 1'b0, ci);
            cyc(1'b0, 1'b0, 1'b0, ci);
        end
    endtask

    // One-cycle CollisionIn pulse on instance A with explicit expectations.
    task automatic hit_a(input string tag, input int exp_count, input bit exp_pulse);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check({tag, ".coll"}, int'(coll_a), exp_count);
        check({tag, ".pulse"}, int'(hp_a), int'(exp_pulse));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".pulse_end"}, int'(hp_a), 0);
    endtask

    initial begin
        bit ci_r = 1'b0;
        Reset = 1'b1; StartGame = 1'b0; FrameTick = 1'b0; CollisionIn = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.coll", int'(coll_a), 0);
        check("rst.disp", int'(de_a), 0);
        check("rst.over", int'(go_a), 0);
        check("rst.pulse", int'(hp_a), 0);
        hit_a("idle_hit", 0, 1'b0);

        // Three spaced hits
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("start.disp", int'(de_a), 1);
        check("start.coll", int'(coll_a), 0);
        for (int k = 1; k <= 3; k++) begin
            hit_a("spaced", k, 1'b1);
            frames(30, 1'b0);
        end
        check("spaced.disp", int'(de_a), 1);

        // Edge five frames into cooldown is ignored
        hit_a("pre_cool", 4, 1'b1);
        frames(5, 1'b0);
        hit_a("in_cool", 4, 1'b0);
        frames(25, 1'b0);

        // Reset in the middle of a cooldown with score 5
        hit_a("five", 5, 1'b1);
        frames(3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst.coll", int'(coll_a), 0);
        check("midrst.disp", int'(de_a), 0);
        check("midrst.over", int'(go_a), 0);
        check("midrst.pulse", int'(hp_a), 0);

        // Level held for 100 frames counts once
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("held.first", int'(coll_a), 1);
        frames(100, 1'b1);
        check("held.a", int'(coll_a), 1);
        check("held.b", int'(coll_b), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        hit_a("reraise", 2, 1'b1);
        check("reraise.b", int'(coll_b), 2);
        frames(30, 1'b0);

        // Hit together with FrameTick loads the full cooldown
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("hit_ft.coll", int'(coll_a), 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        frames(29, 1'b0);
        hit_a("cool_29", 3, 1'b0);
        frames(1, 1'b0);
        hit_a("cool_30", 4, 1'b1);
        frames(30, 1'b0);

        // Game over at ten hits
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (k == 10) begin
                check("go.coll", int'(coll_a), 10);
                check("go.flag", int'(go_a), 1);
            end else begin
                check("go.pre", int'(go_a), 0);
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            frames(30, 1'b0);
        end
        hit_a("go_frozen", 10, 1'b0);
        check("go_frozen.flag", int'(go_a), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart.coll", int'(coll_a), 0);
        check("restart.over", int'(go_a), 0);
        hit_a("restart_armed", 1, 1'b1);

        // Saturation on the no-cooldown build
        pulses_b = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 70; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("sat.coll", int'(coll_b), 63);
        check("sat.pulses", pulses_b, 70);
        check("sat.over", int'(go_b), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("start_hit.coll", int'(coll_b), 0);
        check("start_hit.pulse", int'(hp_b), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized play against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) ci_r = ~ci_r;
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 1499) == 0,
                $urandom_range(0, 2) == 0, ci_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
